// File: rtl/gbtx_sc_pkg.sv
// Shared constants, types and CRC helper for the GBTx slow-control HDLC blocks.
package gbtx_sc_pkg;

  localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
  localparam logic [15:0] CRC16_POLY = 16'h8408;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_GOOD = 16'hF0B8;

  typedef enum logic [2:0] {
    ErrOk       = 3'd0,
    ErrAbort    = 3'd1,
    ErrOverflow = 3'd2,
    ErrCrc      = 3'd3,
    ErrNonOctet = 3'd4,
    ErrShort    = 3'd5
  } errCode_e;

  typedef enum logic [1:0] {
    StHunt,
    StFlag,
    StData
  } rxState_e;

  // Reflected CRC-16/X.25 update, data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crcIn, input logic [7:0] dataIn);
    logic [15:0] crc;
    crc = crcIn;
    for (int i = 0; i < 8; i++) begin
      if (crc[0] ^ dataIn[i]) crc = (crc >> 1) ^ CRC16_POLY;
      else                    crc = crc >> 1;
    end
    return crc;
  endfunction

endpackage

// File: rtl/hdlc_bit_destuff.sv
// HDLC ones counting for two line bits per clock: flag/abort detection and stuff-bit removal.
// lineBits_i[0] is the earlier bit on the line.
module hdlc_bit_destuff (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] lineBits_i,
  output logic [1:0] dataValid_o,
  output logic [1:0] dataBit_o,
  output logic [1:0] flag_o,
  output logic [1:0] abort_o
);

  logic [2:0] onesQ, onesD;

  assign dataBit_o = lineBits_i;

  always_comb begin
    onesD       = onesQ;
    dataValid_o = '0;
    flag_o      = '0;
    abort_o     = '0;
    for (int k = 0; k < 2; k++) begin
      if (lineBits_i[k]) begin
        // A sixth 1 is never data, it can only belong to a flag or an abort.
        case (onesD)
          3'd5: onesD = 3'd6;
          3'd6: begin
            onesD      = 3'd7;
            abort_o[k] = 1'b1;
          end
          3'd7: onesD = 3'd7;
          default: begin
            onesD          = onesD + 3'd1;
            dataValid_o[k] = 1'b1;
          end
        endcase
      end else begin
        if (onesD == 3'd6)      flag_o[k]      = 1'b1;
        else if (onesD != 3'd5) dataValid_o[k] = 1'b1;
        onesD = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) onesQ <= '0;
    else       onesQ <= onesD;
  end

endmodule

// File: rtl/gbtx_sc_hdlc_rx.sv
// GBTx SC elink HDLC receive deframer: flag hunt, destuff, octet assembly, CRC check, FCS strip.
// Optional GBTX_SC_RX_STATS_EN adds saturating good/bad frame counters.
module gbtx_sc_hdlc_rx
  import gbtx_sc_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = 16,
  parameter int unsigned MIN_FRAME_BYTES = 4,
  parameter int unsigned MSB_FIRST       = 1
) (
  input  logic        Clk_ik,
  input  logic        Reset_ira,
  input  logic [1:0]  DataFromGbtxSc_ib2,
  output logic [7:0]  Data_ob8,
  output logic        DataValid_o,
  output logic        FrameStart_o,
  output logic        FrameEnd_o,
  output logic        FrameOk_o,
  output logic [2:0]  ErrCode_ob3,
  output logic        Hunting_o
`ifdef GBTX_SC_RX_STATS_EN
  ,
  output logic [15:0] FrameOkCnt_ob16,
  output logic [15:0] FrameErrCnt_ob16
`endif
);

  localparam int unsigned CntW = $clog2(MAX_FRAME_BYTES + 2);

  logic [1:0] lineBits, bitValid, bitData, bitFlag, bitAbort;

  assign lineBits = (MSB_FIRST != 0) ? {DataFromGbtxSc_ib2[0], DataFromGbtxSc_ib2[1]}
                                     : DataFromGbtxSc_ib2;

  hdlc_bit_destuff uDestuff (
    .clk_i       (Clk_ik),
    .rst_i       (Reset_ira),
    .lineBits_i  (lineBits),
    .dataValid_o (bitValid),
    .dataBit_o   (bitData),
    .flag_o      (bitFlag),
    .abort_o     (bitAbort)
  );

  rxState_e        stateQ, stateD;
  logic [5:0]      pendQ, pendD;
  logic [2:0]      pendCntQ, pendCntD;
  logic [7:0]      asmQ, asmD;
  logic [2:0]      bitCntQ, bitCntD;
  logic [CntW-1:0] byteCntQ, byteCntD;
  logic [15:0]     crcQ, crcD;
  logic [7:0]      hold0Q, hold0D, hold1Q, hold1D;
  logic [1:0]      holdCntQ, holdCntD;
  logic            startedQ, startedD;
  logic [7:0]      dataQ, dataD;
  logic            dataValidQ, dataValidD;
  logic            frameStartQ, frameStartD;
  logic            frameEndQ, frameEndD;
  logic            frameOkQ, frameOkD;
  errCode_e        errQ, errD;

  always_comb begin
    logic leave;
    logic outBit;
    leave       = 1'b0;
    outBit      = 1'b0;
    stateD      = stateQ;
    pendD       = pendQ;
    pendCntD    = pendCntQ;
    asmD        = asmQ;
    bitCntD     = bitCntQ;
    byteCntD    = byteCntQ;
    crcD        = crcQ;
    hold0D      = hold0Q;
    hold1D      = hold1Q;
    holdCntD    = holdCntQ;
    startedD    = startedQ;
    dataD       = dataQ;
    dataValidD  = 1'b0;
    frameStartD = 1'b0;
    frameEndD   = 1'b0;
    frameOkD    = 1'b0;
    errD        = ErrOk;
    for (int k = 0; k < 2; k++) begin
      if (bitAbort[k]) begin
        if (stateD == StData) begin
          frameEndD = 1'b1;
          errD      = ErrAbort;
        end
        stateD = StHunt;
      end else if (bitFlag[k]) begin
        if (stateD == StData) begin
          frameEndD = 1'b1;
          if (bitCntD != 3'd0)                          errD = ErrNonOctet;
          else if (byteCntD < CntW'(MIN_FRAME_BYTES))   errD = ErrShort;
          else if (crcD != CRC16_GOOD)                  errD = ErrCrc;
          else                                          frameOkD = 1'b1;
        end
        // The pending bits are the flag's own 0 and five 1s.
        stateD   = StFlag;
        pendCntD = '0;
        asmD     = '0;
        bitCntD  = '0;
        byteCntD = '0;
        crcD     = CRC16_INIT;
        holdCntD = '0;
        startedD = 1'b0;
      end else if (bitValid[k]) begin
        leave  = (pendCntD == 3'd6);
        outBit = pendD[5];
        pendD  = {pendD[4:0], bitData[k]};
        if (!leave) pendCntD = pendCntD + 3'd1;
        if (leave && stateD != StHunt) begin
          stateD  = StData;
          asmD    = {outBit, asmD[7:1]};
          bitCntD = bitCntD + 3'd1;
          if (bitCntD == 3'd0) begin
            crcD     = crc16_byte(crcD, asmD);
            byteCntD = byteCntD + CntW'(1);
            // The last two bytes seen may be the FCS, so payload lags by two bytes.
            if (holdCntD == 2'd2) begin
              dataValidD  = 1'b1;
              dataD       = hold0D;
              frameStartD = !startedD;
              startedD    = 1'b1;
              hold0D      = hold1D;
              hold1D      = asmD;
            end else if (holdCntD == 2'd1) begin
              hold1D   = asmD;
              holdCntD = 2'd2;
            end else begin
              hold0D   = asmD;
              holdCntD = 2'd1;
            end
            if (byteCntD == CntW'(MAX_FRAME_BYTES + 1)) begin
              frameEndD = 1'b1;
              errD      = ErrOverflow;
              stateD    = StHunt;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge Clk_ik or posedge Reset_ira) begin
    if (Reset_ira) begin
      stateQ      <= StHunt;
      pendQ       <= '0;
      pendCntQ    <= '0;
      asmQ        <= '0;
      bitCntQ     <= '0;
      byteCntQ    <= '0;
      crcQ        <= CRC16_INIT;
      hold0Q      <= '0;
      hold1Q      <= '0;
      holdCntQ    <= '0;
      startedQ    <= 1'b0;
      dataQ       <= '0;
      dataValidQ  <= 1'b0;
      frameStartQ <= 1'b0;
      frameEndQ   <= 1'b0;
      frameOkQ    <= 1'b0;
      errQ        <= ErrOk;
    end else begin
      stateQ      <= stateD;
      pendQ       <= pendD;
      pendCntQ    <= pendCntD;
      asmQ        <= asmD;
      bitCntQ     <= bitCntD;
      byteCntQ    <= byteCntD;
      crcQ        <= crcD;
      hold0Q      <= hold0D;
      hold1Q      <= hold1D;
      holdCntQ    <= holdCntD;
      startedQ    <= startedD;
      dataQ       <= dataD;
      dataValidQ  <= dataValidD;
      frameStartQ <= frameStartD;
      frameEndQ   <= frameEndD;
      frameOkQ    <= frameOkD;
      errQ        <= errD;
    end
  end

  assign Data_ob8     = dataQ;
  assign DataValid_o  = dataValidQ;
  assign FrameStart_o = frameStartQ;
  assign FrameEnd_o   = frameEndQ;
  assign FrameOk_o    = frameOkQ;
  assign ErrCode_ob3  = errQ;
  assign Hunting_o    = (stateQ == StHunt);

`ifdef GBTX_SC_RX_STATS_EN
  logic [15:0] okCntQ, errCntQ;

  always_ff @(posedge Clk_ik or posedge Reset_ira) begin
    if (Reset_ira) begin
      okCntQ  <= '0;
      errCntQ <= '0;
    end else if (frameEndQ) begin
      if (frameOkQ) begin
        if (okCntQ != 16'hFFFF) okCntQ <= okCntQ + 16'd1;
      end else begin
        if (errCntQ != 16'hFFFF) errCntQ <= errCntQ + 16'd1;
      end
    end
  end

  assign FrameOkCnt_ob16  = okCntQ;
  assign FrameErrCnt_ob16 = errCntQ;
`endif

endmodule

// File: doc/gbtx_sc_hdlc_rx.md
Name: gbtx_sc_hdlc_rx

Overview:
- Receive deframer for the GBTx Slow Control elink.
- Consumes the 2-bit SC stream that the system module delivers every clock, and recovers HDLC frames: flag hunting, zero-bit destuffing, octet assembly, CRC-16 check and FCS stripping.
- Presents payload bytes with framing strobes to the application-side SC command decoder.

Parameters:
- MAX_FRAME_BYTES, 16: maximum bytes between flags, including the 2 FCS bytes; a longer frame is an overflow error.
- MIN_FRAME_BYTES, 4: minimum bytes, including FCS; shorter non-empty frames are a short error.
- MSB_FIRST, 1: 1 = bit[1] of the 2-bit input is earlier on the line; 0 = bit[0] is earlier.

Ports:
- Clk_ik  in  1  elink clock (40 MHz, chip global)
- Reset_ira  in  1  asynchronous, active-high reset
- DataFromGbtxSc_ib2  in  2  SC elink bits, valid every cycle
- Data_ob8  out  8  payload byte, LSB received first
- DataValid_o  out  1  one-cycle strobe for Data_ob8
- FrameStart_o  out  1  coincident with DataValid_o of the first payload byte
- FrameEnd_o  out  1  one-cycle pulse, frame closed or terminated
- FrameOk_o  out  1  qualifies FrameEnd_o: frame good
- ErrCode_ob3  out  3  valid with FrameEnd_o: 0 ok, 1 abort, 2 overflow, 3 CRC, 4 non-octet, 5 short
- Hunting_o  out  1  high while in HUNT

Behaviour:
- Reset value of every output is 0, except Hunting_o = 1. Reset is asynchronous and active-high, one clock, no other clocks.
- Bit processing:
  - Both bits are processed in line order within one cycle; the logic is unrolled twice.
  - State carried between the two bits: ones counter, pending register, assembler, CRC.
- Raw ones counter c, per bit:
  - 1: c++.
  - 0 with c = 5: stuffed bit, dropped; c = 0.
  - 0 with c = 6: flag.
  - 0 otherwise: data; c = 0.
  - c reaching 7: abort.
- Pending delay:
  - Destuffed bits pass through a 6-bit pending delay before the byte assembler.
  - On a flag, the 6 pending bits (the flag's 0 and five 1s) are discarded.
- States:
  - HUNT: ignore data; any flag -> FLAG.
  - FLAG: further flags stay in FLAG (back-to-back flags are empty frames, no outputs); the first data bit leaving the pending delay -> DATA.
  - DATA: assemble bytes LSB-first. Each completed byte updates the CRC-16/X.25 (reflected 0x8408, init 0xFFFF) and enters a 2-byte hold-back FIFO.
    - When a third byte arrives, the oldest byte is emitted: DataValid_o pulses 1 cycle after that byte completes.
    - Closing flag -> FLAG. The 2 held bytes are the FCS and are never emitted.
    - Abort -> HUNT.
- Frame-end checks, in priority order, on the closing flag:
  - Assembler bit count != 0 -> error 4.
  - Byte count < MIN_FRAME_BYTES -> error 5.
  - CRC register != 0xF0B8 -> error 3.
  - Otherwise FrameOk_o = 1, ErrCode_ob3 = 0.
- Error terminations:
  - Overflow: byte count reaching MAX_FRAME_BYTES + 1 -> FrameEnd_o with error 2, then HUNT; the remaining bytes are discarded.
  - Abort -> FrameEnd_o with error 1.
  - FrameEnd_o pulses 1 cycle after the cycle containing the terminating bit.
- Boundary rules:
  - FrameEnd_o is emitted only for frames with at least 1 assembled bit.
  - A frame closing before any payload byte is emitted still gives FrameEnd_o, with FrameStart_o never asserted.
  - If a byte emission and FrameEnd_o fall in the same cycle, both are asserted, and the byte belongs to the ending frame.
  - A flag's final 0 and the next frame's first data bit may share a cycle; no bit is lost.
- Throughput: at most one byte per 4 cycles, so no backpressure port exists.
- Reset mid-frame: state is cleared; no FrameEnd_o is emitted for the interrupted frame.

Optional Feature:
- GBTX_SC_RX_STATS_EN defined: adds outputs FrameOkCnt_ob16 and FrameErrCnt_ob16. These are saturating counters, incremented on FrameEnd_o according to FrameOk_o, and reset to 0.
- Undefined: the ports and counters are absent.

Decomposition:
- Shared package gbtx_sc_pkg holds:
  - HDLC_FLAG = 8'h7E
  - CRC16_POLY = 16'h8408
  - CRC16_INIT = 16'hFFFF
  - CRC16_GOOD = 16'hF0B8
  - ErrCode enum
  - the crc16_byte function
- One sub-module is natural: hdlc_bit_destuff. It handles the ones counter, flag/abort detection and stuff removal for 2 bits per cycle, and outputs up to 2 data bits plus flag and abort events with their bit positions.
- The byte assembler, hold-back FIFO, CRC and FSM stay in the top module.

Test Plan:
- Continuous 0x7E idle for 200 cycles -> no DataValid_o or FrameEnd_o; Hunting_o = 0 after the first flag.
- Flag, payload 0x01 0x02 0x03, correct FCS (bench model), flag -> 3 DataValid_o with values 01, 02, 03; FrameStart_o on 01; FrameEnd_o with FrameOk_o = 1, ErrCode = 0.
- Payload 0x1F 0xFF 0x7E 0x3E with stuffing on the line -> the exact 4 bytes out, FrameOk_o = 1. Repeat with MSB_FIRST = 0 and the bit order swapped.
- Same frame with one FCS bit flipped -> payload emitted, FrameEnd_o with FrameOk_o = 0, ErrCode = 3.
- Seven 1s mid-frame -> FrameEnd_o with ErrCode = 1, Hunting_o = 1. Then 17 bytes with MAX = 16 -> ErrCode = 2. Then a 3-bit frame -> ErrCode = 4.
- Reset_ira pulsed mid-frame -> all outputs 0 asynchronously, no FrameEnd_o; the next valid frame is received OK. With GBTX_SC_RX_STATS_EN, the counters read ok = 1, err = 0.
